// File: rtl/lorenz_pkg.sv
// Shared types, constants and saturating helpers for the Lorenz run controller.
// Saturating helpers are only used when LORENZ_SATURATE_EN is defined.
package lorenz_pkg;

  localparam int DEF_W  = 34;
  localparam int DEF_CW = 16;
  localparam int DEF_DW = 8;

  localparam int SH_X  = 5;
  localparam int SH_Z1 = 2;
  localparam int SH_Z2 = 4;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  typedef struct packed {
    logic [DEF_W-1:0] val;
    logic             ovf;
  } sat_t;

  localparam logic [DEF_W-1:0] SAT_MAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] SAT_MIN = {1'b1, {(DEF_W-1){1'b0}}};

  function automatic sat_t sat_add(input logic [DEF_W-1:0] a, input logic [DEF_W-1:0] b);
    sat_t r;
    r.val = a + b;
    r.ovf = (a[DEF_W-1] == b[DEF_W-1]) && (r.val[DEF_W-1] != a[DEF_W-1]);
    if (r.ovf) r.val = a[DEF_W-1] ? SAT_MIN : SAT_MAX;
    return r;
  endfunction

  function automatic sat_t sat_sub(input logic [DEF_W-1:0] a, input logic [DEF_W-1:0] b);
    sat_t r;
    r.val = a - b;
    r.ovf = (a[DEF_W-1] != b[DEF_W-1]) && (r.val[DEF_W-1] != a[DEF_W-1]);
    if (r.ovf) r.val = a[DEF_W-1] ? SAT_MIN : SAT_MAX;
    return r;
  endfunction

endpackage

// File: rtl/lorenz_step.sv
// One combinational Lorenz iteration step (x,y,z) -> (x',y',z').
// LORENZ_SATURATE_EN selects clipping arithmetic and adds the ovf_o output.
module lorenz_step
  import lorenz_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
`ifdef LORENZ_SATURATE_EN
  output logic         ovf_o,
`endif
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic [W-1:0] z_o
);

  logic g;
  assign g = ~x_i[W-1];

`ifdef LORENZ_SATURATE_EN
  sat_t dxy, xn, ya, ys, neg, t, zn;
  logic [W-1:0] xg;

  always_comb begin
    dxy   = sat_sub(y_i, x_i);
    xn    = sat_add(x_i, W'($signed(dxy.val) >>> SH_X));
    ya    = sat_add(y_i, z_i);
    ys    = sat_sub(y_i, z_i);
    neg   = sat_sub('0, x_i);
    xg    = g ? x_i : neg.val;
    t     = sat_add(W'($signed(z_i) >>> SH_Z1), xg);
    zn    = sat_sub(z_i, W'($signed(t.val) >>> SH_Z2));
    x_o   = xn.val;
    y_o   = g ? ya.val : ys.val;
    z_o   = zn.val;
    // Only clips on the branch actually taken count as overflow.
    ovf_o = dxy.ovf | xn.ovf | (g ? ya.ovf : (ys.ovf | neg.ovf)) | t.ovf | zn.ovf;
  end
`else
  logic signed [W-1:0] xs, ys, zs, dxy, xg, t;

  always_comb begin
    xs  = $signed(x_i);
    ys  = $signed(y_i);
    zs  = $signed(z_i);
    dxy = ys - xs;
    xg  = g ? xs : -xs;
    t   = (zs >>> SH_Z1) + xg;
    x_o = xs + (dxy >>> SH_X);
    y_o = g ? ys + zs : ys - zs;
    z_o = zs - (t >>> SH_Z2);
  end
`endif

endmodule

// File: rtl/lorenz_run_ctrl.sv
// Lorenz iterator sequencer: seed load, stepped run, decimated valid/ready samples.
// Define LORENZ_SATURATE_EN for saturating arithmetic and the sticky ovf_flag port.
module lorenz_run_ctrl
  import lorenz_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] num_steps,
  input  logic [DW-1:0] decim,
  input  logic [W-1:0]  x0,
  input  logic [W-1:0]  y0,
  input  logic [W-1:0]  z0,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic [W-1:0]  out_z,
`ifdef LORENZ_SATURATE_EN
  output logic          ovf_flag,
`endif
  output logic [CW-1:0] step_cnt
);

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [W-1:0]  ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d, num_steps_q, num_steps_d;
  logic [DW-1:0] decim_cnt_q, decim_cnt_d, decim_q, decim_d, decim_eff;
  logic          out_valid_q, out_valid_d, done_q, done_d;
  logic [W-1:0]  x_n, y_n, z_n;
  logic          stall;
  logic          step_ovf;

  lorenz_step #(.W(W)) u_step (
    .x_i   (x_q),
    .y_i   (y_q),
    .z_i   (z_q),
`ifdef LORENZ_SATURATE_EN
    .ovf_o (step_ovf),
`endif
    .x_o   (x_n),
    .y_o   (y_n),
    .z_o   (z_n)
  );

`ifdef LORENZ_SATURATE_EN
  logic ovf_q, ovf_d;
  assign ovf_flag = ovf_q;
`else
  assign step_ovf = 1'b0;
`endif

  assign stall     = out_valid_q && !out_ready;
  assign decim_eff = (decim_q == '0) ? DW'(1) : decim_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    oz_d        = oz_q;
    step_cnt_d  = step_cnt_q;
    num_steps_d = num_steps_q;
    decim_cnt_d = decim_cnt_q;
    decim_d     = decim_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
`ifdef LORENZ_SATURATE_EN
    ovf_d       = ovf_q;
`endif
    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            x_d         = x0;
            y_d         = y0;
            z_d         = z0;
            num_steps_d = num_steps;
            decim_d     = decim;
            step_cnt_d  = '0;
            decim_cnt_d = '0;
            out_valid_d = 1'b0;
`ifdef LORENZ_SATURATE_EN
            ovf_d       = 1'b0;
`endif
            if (num_steps == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN, HOLD: begin
          if (stall) begin
            state_d = HOLD;
          end else begin
            // Not stalled: any pending sample is accepted this cycle.
            state_d     = RUN;
            out_valid_d = 1'b0;
            if (step_cnt_q == num_steps_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              x_d        = x_n;
              y_d        = y_n;
              z_d        = z_n;
              step_cnt_d = step_cnt_q + CW'(1);
`ifdef LORENZ_SATURATE_EN
              ovf_d      = ovf_q | step_ovf;
`endif
              if (decim_cnt_q + DW'(1) == decim_eff) begin
                ox_d        = x_n;
                oy_d        = y_n;
                oz_d        = z_n;
                out_valid_d = 1'b1;
                decim_cnt_d = '0;
              end else begin
                decim_cnt_d = decim_cnt_q + DW'(1);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      oz_q        <= '0;
      step_cnt_q  <= '0;
      num_steps_q <= '0;
      decim_cnt_q <= '0;
      decim_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef LORENZ_SATURATE_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      oz_q        <= oz_d;
      step_cnt_q  <= step_cnt_d;
      num_steps_q <= num_steps_d;
      decim_cnt_q <= decim_cnt_d;
      decim_q     <= decim_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef LORENZ_SATURATE_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == RUN) || (state_q == HOLD);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_z     = oz_q;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_lorenz_run_ctrl.sv
// Directed self-checking bench for lorenz_run_ctrl (default wrap-around build).
module tb_lorenz_run_ctrl;

  localparam int W  = 34;
  localparam int CW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, out_ready;
  logic [CW-1:0] num_steps;
  logic [DW-1:0] decim;
  logic [W-1:0]  x0, y0, z0;
  logic          busy, done, out_valid;
  logic [W-1:0]  out_x, out_y, out_z;
  logic [CW-1:0] step_cnt;
`ifdef LORENZ_SATURATE_EN
  logic          ovf_flag;
`endif

  int checks = 0;
  int errors = 0;
  int k;

  logic [W-1:0] mx [0:15];
  logic [W-1:0] my [0:15];
  logic [W-1:0] mz [0:15];

  lorenz_run_ctrl #(.W(W), .CW(CW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .num_steps (num_steps),
    .decim     (decim),
    .x0        (x0),
    .y0        (y0),
    .z0        (z0),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
`ifdef LORENZ_SATURATE_EN
    .ovf_flag  (ovf_flag),
`endif
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*W-1:0] model_step(input logic [3*W-1:0] s);
    logic signed [W-1:0] x, y, z, d, t, xg, nx, ny, nz;
    x  = s[3*W-1 -: W];
    y  = s[2*W-1 -: W];
    z  = s[W-1:0];
    d  = y - x;
    nx = x + (d >>> 5);
    ny = !x[W-1] ? y + z : y - z;
    xg = !x[W-1] ? x : -x;
    t  = (z >>> 2) + xg;
    nz = z - (t >>> 4);
    return {nx, ny, nz};
  endfunction

  task automatic fill_model(input logic [W-1:0] sx, input logic [W-1:0] sy, input logic [W-1:0] sz);
    logic [3*W-1:0] s;
    s = {sx, sy, sz};
    for (int i = 0; i < 16; i++) begin
      {mx[i], my[i], mz[i]} = s;
      s = model_step(s);
    end
  endtask

  task automatic launch(input logic [W-1:0] sx, input logic [W-1:0] sy, input logic [W-1:0] sz,
                        input int n, input int d);
    x0 = sx; y0 = sy; z0 = sz;
    num_steps = CW'(n);
    decim = DW'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done (bounded); every emitted sample is checked against the model.
  task automatic collect(input int d, input int k0, input int max_cyc, output int kout);
    bit seen;
    int kk;
    seen = 0;
    kk = k0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      tick();
      if (out_valid) begin
        kk++;
        chk("smp_step", W'(step_cnt), W'(d * kk));
        if (d * kk < 16) begin
          chk("smp_x", out_x, mx[d*kk]);
          chk("smp_y", out_y, my[d*kk]);
          chk("smp_z", out_z, mz[d*kk]);
        end
      end
      if (done) seen = 1;
    end
    chk("done_seen", W'(seen), W'(1));
    kout = kk;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    num_steps = '0; decim = '0; x0 = '0; y0 = '0; z0 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_step", W'(step_cnt), W'(0));
    chk("rst_x", out_x, W'(0));

    // 1: single step from (0,32,0)
    launch(W'(0), W'(32), W'(0), 1, 1);
    chk("t1_busy", W'(busy), W'(1));
    chk("t1_novalid", W'(out_valid), W'(0));
    tick();
    chk("t1_valid", W'(out_valid), W'(1));
    chk("t1_x", out_x, W'(1));
    chk("t1_y", out_y, W'(32));
    chk("t1_z", out_z, W'(0));
    chk("t1_step", W'(step_cnt), W'(1));
    tick();
    chk("t1_done", W'(done), W'(1));
    chk("t1_valid_clr", W'(out_valid), W'(0));
    chk("t1_idle", W'(busy), W'(0));
    tick();
    chk("t1_done_pulse", W'(done), W'(0));

    // 2: zero steps
    launch(W'(5), W'(6), W'(7), 0, 1);
    chk("t2_done", W'(done), W'(1));
    chk("t2_valid", W'(out_valid), W'(0));
    chk("t2_step", W'(step_cnt), W'(0));
    chk("t2_busy", W'(busy), W'(0));
    tick();
    chk("t2_done_pulse", W'(done), W'(0));

    // 3: decimation by 3 over 10 steps
    fill_model(W'(-64), W'(100), W'(40));
    launch(W'(-64), W'(100), W'(40), 10, 3);
    collect(3, 0, 40, k);
    chk("t3_nsamp", W'(k), W'(3));
    chk("t3_step", W'(step_cnt), W'(10));
    chk("t3_valid", W'(out_valid), W'(0));

    // 4: backpressure after first sample
    out_ready = 1'b0;
    launch(W'(-64), W'(100), W'(40), 8, 1);
    tick();
    chk("t4_valid", W'(out_valid), W'(1));
    chk("t4_x1", out_x, W'(-59));
    chk("t4_y1", out_y, W'(60));
    chk("t4_z1", out_z, W'(36));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", W'(out_valid), W'(1));
      chk("t4_hold_x", out_x, W'(-59));
      chk("t4_hold_step", W'(step_cnt), W'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("t4_x2", out_x, W'(-56));
    chk("t4_y2", out_y, W'(24));
    chk("t4_z2", out_z, W'(32));
    collect(1, 2, 40, k);
    chk("t4_nsamp", W'(k), W'(8));

    // decim = 0 behaves as 1
    launch(W'(-64), W'(100), W'(40), 2, 0);
    collect(1, 0, 20, k);
    chk("d0_nsamp", W'(k), W'(2));

    // 5: abort at step 4 of 100, then restart
    launch(W'(-64), W'(100), W'(40), 100, 1);
    tick(); tick(); tick(); tick();
    chk("t5_step4", W'(step_cnt), W'(4));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", W'(busy), W'(0));
    chk("t5_valid", W'(out_valid), W'(0));
    chk("t5_done", W'(done), W'(0));
    tick(); tick();
    chk("t5_nodone", W'(done), W'(0));
    launch(W'(-64), W'(100), W'(40), 5, 1);
    collect(1, 0, 20, k);
    chk("t5_nsamp", W'(k), W'(5));

    // start with abort in the same cycle: abort wins
    abort = 1'b1;
    launch(W'(-64), W'(100), W'(40), 5, 1);
    abort = 1'b0;
    chk("sa_busy", W'(busy), W'(0));
    tick();
    chk("sa_valid", W'(out_valid), W'(0));

    // 6: start while busy ignored, then async reset during HOLD
    out_ready = 1'b0;
    launch(W'(-64), W'(100), W'(40), 8, 1);
    tick(); tick();
    launch(W'(0), W'(32), W'(0), 1, 1);
    chk("t6_ign_x", out_x, W'(-59));
    chk("t6_ign_step", W'(step_cnt), W'(1));
    chk("t6_ign_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_busy", W'(busy), W'(0));
    chk("t6_valid", W'(out_valid), W'(0));
    chk("t6_x", out_x, W'(0));
    chk("t6_y", out_y, W'(0));
    chk("t6_step", W'(step_cnt), W'(0));
    chk("t6_done", W'(done), W'(0));
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_after_busy", W'(busy), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
